// File: rtl/priv_pkg.sv
// -----------------------------------------------------------------------------
// priv_pkg
// Shared constants and types for the privileged SYSTEM-instruction executor:
// opcode/funct3 match values, funct12 immediates for ECALL/EBREAK/WFI/MRET/SRET,
// exception cause codes, privilege-level encodings, the FSM state type and the
// captured-result record.
// -----------------------------------------------------------------------------
package priv_pkg;

    localparam logic [6:0]  SYSTEM_OPCODE = 7'b1110011;
    localparam logic [2:0]  PRIV_FUNCT3   = 3'b000;

    localparam logic [11:0] IMM_ECALL  = 12'h000;
    localparam logic [11:0] IMM_EBREAK = 12'h001;
    localparam logic [11:0] IMM_SRET   = 12'h102;
    localparam logic [11:0] IMM_WFI    = 12'h105;
    localparam logic [11:0] IMM_MRET   = 12'h302;

    localparam logic [5:0]  CAUSE_ILLEGAL    = 6'd2;
    localparam logic [5:0]  CAUSE_BREAKPOINT = 6'd3;
    localparam logic [5:0]  CAUSE_ECALL_U    = 6'd8;
    localparam logic [5:0]  CAUSE_ECALL_S    = 6'd9;
    localparam logic [5:0]  CAUSE_ECALL_M    = 6'd11;

    localparam logic [1:0]  PRIV_U    = 2'd0;
    localparam logic [1:0]  PRIV_S    = 2'd1;
    localparam logic [1:0]  PRIV_RSVD = 2'd2;
    localparam logic [1:0]  PRIV_M    = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WFI_WAIT = 2'd1,
        RESP     = 2'd2
    } state_t;

    // Result captured at accept time and presented during RESP.
    typedef struct packed {
        logic       exc;
        logic [5:0] num;
        logic       ret;
        logic       sret;
    } result_t;

endpackage

// File: rtl/execute_system_priv_if.sv
// -----------------------------------------------------------------------------
// execute_system_priv_if
// Bundle between the decode/pipeline side and the privileged executor.
//   master : drives decode fields, read_valid, priv_mode, interrupt_pending,
//            flush; observes the result signals.
//   slave  : the executor; observes the request, drives processing, valid,
//            exception_*/exception_return_* and wfi_active.
// -----------------------------------------------------------------------------
interface execute_system_priv_if;

    logic [6:0]  decode_opcode;
    logic [2:0]  decode_funct3;
    logic [6:0]  decode_funct7;
    logic [11:0] decode_imm;
    logic        read_valid;
    logic [1:0]  priv_mode;
    logic        interrupt_pending;
    logic        flush;

    logic        processing;
    logic        valid;
    logic [5:0]  exception_num_out;
    logic        exception_valid_out;
    logic        exception_return_valid_out;
    logic        exception_return_sret_out;
    logic        wfi_active;

    modport master (
        output decode_opcode, decode_funct3, decode_funct7, decode_imm,
               read_valid, priv_mode, interrupt_pending, flush,
        input  processing, valid, exception_num_out, exception_valid_out,
               exception_return_valid_out, exception_return_sret_out, wfi_active
    );

    modport slave (
        input  decode_opcode, decode_funct3, decode_funct7, decode_imm,
               read_valid, priv_mode, interrupt_pending, flush,
        output processing, valid, exception_num_out, exception_valid_out,
               exception_return_valid_out, exception_return_sret_out, wfi_active
    );

endinterface

// File: rtl/wfi_timer.sv
// -----------------------------------------------------------------------------
// wfi_timer
// Saturating cycle counter used while the executor sits in WFI_WAIT.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (entry to WFI_WAIT, flush)
//   enable     : count this cycle
//   expired    : count has reached WFI_TIMEOUT-1 (never when WFI_TIMEOUT=0)
// -----------------------------------------------------------------------------
module wfi_timer #(
    parameter int WFI_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(WFI_TIMEOUT) + 1;
    // Holding value. For WFI_TIMEOUT=0 this truncates to all-ones, so the
    // counter simply parks at its maximum and expired stays low.
    localparam logic [CW-1:0] LIMIT = CW'(WFI_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (WFI_TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/execute_system_priv.sv
// -----------------------------------------------------------------------------
// execute_system_priv
// Sequential executor for SYSTEM/funct3=000 instructions (ECALL, EBREAK, MRET,
// SRET, WFI). Checks the instruction against the current privilege mode,
// captures the outcome at accept time and presents it with a one-cycle valid
// pulse. WFI parks the block in WFI_WAIT until an interrupt is pending or the
// configurable timeout expires.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : execute_system_priv_if.slave (decode fields, read_valid,
//                priv_mode, interrupt_pending, flush in; processing, valid,
//                exception/return results and wfi_active out)
// Parameters: WFI_TIMEOUT (0 = wait forever), S_MODE_EN (SRET + S-mode ECALL).
// -----------------------------------------------------------------------------
module execute_system_priv
    import priv_pkg::*;
#(
    parameter int WFI_TIMEOUT = 1024,
    parameter bit S_MODE_EN   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    execute_system_priv_if.slave    bus
);

    state_t  state_q, state_d;
    result_t res_p0, res_p1;
    logic    match, is_wfi, capture;
    logic    timer_clr, timer_en, timer_expired;
    logic    vld_p1;

    // funct7 is carried for port compatibility only.
    logic    unused_funct7;
    assign unused_funct7 = ^bus.decode_funct7;

    function automatic logic [5:0] ecall_cause(input logic [1:0] pm);
        case (pm)
            PRIV_M:  return CAUSE_ECALL_M;
            PRIV_S:  return S_MODE_EN ? CAUSE_ECALL_S : CAUSE_ECALL_M;
            default: return CAUSE_ECALL_U;   // U and reserved
        endcase
    endfunction

    // ---- p0: decode and privilege check ----
    always_comb begin
        match  = 1'b0;
        is_wfi = 1'b0;
        res_p0 = '0;
        if (bus.read_valid && (bus.decode_opcode == SYSTEM_OPCODE) &&
            (bus.decode_funct3 == PRIV_FUNCT3)) begin
            case (bus.decode_imm)
                IMM_ECALL: begin
                    match      = 1'b1;
                    res_p0.exc = 1'b1;
                    res_p0.num = ecall_cause(bus.priv_mode);
                end
                IMM_EBREAK: begin
                    match      = 1'b1;
                    res_p0.exc = 1'b1;
                    res_p0.num = CAUSE_BREAKPOINT;
                end
                IMM_MRET: begin
                    match = 1'b1;
                    if (bus.priv_mode == PRIV_M) begin
                        res_p0.ret = 1'b1;
                    end else begin
                        res_p0.exc = 1'b1;
                        res_p0.num = CAUSE_ILLEGAL;
                    end
                end
                IMM_SRET: begin
                    if (S_MODE_EN) begin
                        match = 1'b1;
                        if ((bus.priv_mode == PRIV_S) || (bus.priv_mode == PRIV_M)) begin
                            res_p0.ret  = 1'b1;
                            res_p0.sret = 1'b1;
                        end else begin
                            res_p0.exc = 1'b1;
                            res_p0.num = CAUSE_ILLEGAL;
                        end
                    end
                end
                IMM_WFI: begin
                    match  = 1'b1;
                    is_wfi = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush overrides everything, including a match arriving in IDLE.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        if (bus.flush) begin
            state_d   = IDLE;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        capture   = 1'b1;
                        timer_clr = is_wfi;
                        state_d   = is_wfi ? WFI_WAIT : RESP;
                    end
                end
                WFI_WAIT: begin
                    timer_en = 1'b1;
                    if (bus.interrupt_pending || timer_expired) begin
                        state_d = RESP;
                    end
                end
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    wfi_timer #(
        .WFI_TIMEOUT (WFI_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // ---- p1: captured result, presented in RESP ----
    always_ff @(posedge clk) begin
        if (capture) begin
            res_p1 <= res_p0;
        end
    end

    // A flush during RESP kills the strobe in the same cycle.
    assign vld_p1 = (state_q == RESP) && !bus.flush;

    assign bus.valid                      = vld_p1;
    assign bus.exception_valid_out        = vld_p1 && res_p1.exc;
    assign bus.exception_num_out          = (vld_p1 && res_p1.exc) ? res_p1.num : 6'd0;
    assign bus.exception_return_valid_out = vld_p1 && res_p1.ret;
    assign bus.exception_return_sret_out  = vld_p1 && res_p1.ret && res_p1.sret;
    assign bus.wfi_active                 = (state_q == WFI_WAIT);
    assign bus.processing                 = ((state_q == IDLE) && match) || (state_q != IDLE);

endmodule

// File: tb/tb_execute_system_priv.sv
// -----------------------------------------------------------------------------
// tb_execute_system_priv
// Three executors share one set of decode/priv/interrupt/flush drivers, each
// with its own read_valid:
//   dut_a : WFI_TIMEOUT=1024, S_MODE_EN=1
//   dut_b : WFI_TIMEOUT=4,    S_MODE_EN=1
//   dut_c : WFI_TIMEOUT=0,    S_MODE_EN=0
// Expected results (with the negedge count at which valid must appear) are
// queued at stimulus time; a monitor pops and compares on every valid.
// -----------------------------------------------------------------------------
module tb_execute_system_priv;

    localparam logic [6:0]  OP_SYS = 7'b1110011;
    localparam logic [11:0] I_ECALL = 12'h000, I_EBREAK = 12'h001, I_SRET = 12'h102,
                            I_WFI = 12'h105, I_MRET = 12'h302;

    typedef struct {
        logic       exc;
        logic [5:0] num;
        logic       ret;
        logic       sret;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [11:0] imm = '0;
    logic [1:0]  priv = '0;
    logic        intp = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  rv = '0;

    int compared = 0;
    int mismatched = 0;
    int ncyc = 0;
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    execute_system_priv_if if_a ();
    execute_system_priv_if if_b ();
    execute_system_priv_if if_c ();

    assign if_a.decode_opcode = opcode;  assign if_b.decode_opcode = opcode;  assign if_c.decode_opcode = opcode;
    assign if_a.decode_funct3 = funct3;  assign if_b.decode_funct3 = funct3;  assign if_c.decode_funct3 = funct3;
    assign if_a.decode_funct7 = funct7;  assign if_b.decode_funct7 = funct7;  assign if_c.decode_funct7 = funct7;
    assign if_a.decode_imm = imm;        assign if_b.decode_imm = imm;        assign if_c.decode_imm = imm;
    assign if_a.priv_mode = priv;        assign if_b.priv_mode = priv;        assign if_c.priv_mode = priv;
    assign if_a.interrupt_pending = intp; assign if_b.interrupt_pending = intp; assign if_c.interrupt_pending = intp;
    assign if_a.flush = flush;           assign if_b.flush = flush;           assign if_c.flush = flush;
    assign if_a.read_valid = rv[0];      assign if_b.read_valid = rv[1];      assign if_c.read_valid = rv[2];

    execute_system_priv #(.WFI_TIMEOUT(1024), .S_MODE_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    execute_system_priv #(.WFI_TIMEOUT(4),    .S_MODE_EN(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    execute_system_priv #(.WFI_TIMEOUT(0),    .S_MODE_EN(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic exc, input logic [5:0] num,
                            input logic ret, input logic sret, input int cyc);
        exp_t e;
        e.exc = exc; e.num = num; e.ret = ret; e.sret = sret; e.cyc = cyc;
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int id, input logic v, input logic exc, input logic [5:0] num,
                       input logic ret, input logic sret);
        exp_t e;
        int   n;
        if (v) begin
            n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
            compared++;
            if (n == 0) begin
                mismatched++;
                $display("FAIL unexpected_valid dut%0d: valid=1 at cycle %0d, expected none", id, ncyc);
            end else begin
                case (id)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                if (exc !== e.exc || num !== e.num || ret !== e.ret || sret !== e.sret || ncyc != e.cyc) begin
                    mismatched++;
                    $display("FAIL result dut%0d: got exc=%0d num=%0d ret=%0d sret=%0d cyc=%0d, expected exc=%0d num=%0d ret=%0d sret=%0d cyc=%0d",
                             id, exc, num, ret, sret, ncyc, e.exc, e.num, e.ret, e.sret, e.cyc);
                end
            end
        end
    endtask

    // Monitor: counts negedges and checks every valid strobe.
    initial begin
        forever begin
            @(negedge clk);
            ncyc = ncyc + 1;
            mon(0, if_a.valid, if_a.exception_valid_out, if_a.exception_num_out,
                if_a.exception_return_valid_out, if_a.exception_return_sret_out);
            mon(1, if_b.valid, if_b.exception_valid_out, if_b.exception_num_out,
                if_b.exception_return_valid_out, if_b.exception_return_sret_out);
            mon(2, if_c.valid, if_c.exception_valid_out, if_c.exception_num_out,
                if_c.exception_return_valid_out, if_c.exception_return_sret_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic [11:0] im, input logic [1:0] pm);
        opcode = OP_SYS;
        funct3 = 3'b000;
        imm    = im;
        priv   = pm;
        rv     = 3'b000;
        rv[id] = 1'b1;
    endtask

    // Non-WFI instruction: one accept cycle, one idle cycle; valid expected
    // right after the accept edge.
    task automatic issue(input int id, input logic [11:0] im, input logic [1:0] pm,
                         input logic exc, input logic [5:0] num, input logic ret, input logic sret);
        drive(id, im, pm);
        push_exp(id, exc, num, ret, sret, ncyc + 2);
        tick();
        rv = 3'b000;
        tick();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(if_a.valid), 0);
        chk("rst_exc_valid", 32'(if_a.exception_valid_out), 0);
        chk("rst_ret_valid", 32'(if_a.exception_return_valid_out), 0);
        chk("rst_wfi_active", 32'(if_a.wfi_active), 0);
        chk("rst_processing", 32'(if_a.processing), 0);
        rst_n = 1'b1;
        tick(); tick();

        // ECALL across privilege levels
        issue(0, I_ECALL, 2'd3, 1, 6'd11, 0, 0);
        issue(0, I_ECALL, 2'd0, 1, 6'd8, 0, 0);
        issue(0, I_ECALL, 2'd1, 1, 6'd9, 0, 0);
        issue(0, I_ECALL, 2'd2, 1, 6'd8, 0, 0);

        // EBREAK then MRET back to back: strobes two cycles apart
        issue(0, I_EBREAK, 2'd3, 1, 6'd3, 0, 0);
        issue(0, I_MRET, 2'd3, 0, 6'd0, 1, 0);

        // xRET privilege checks
        issue(0, I_MRET, 2'd1, 1, 6'd2, 0, 0);
        issue(0, I_SRET, 2'd0, 1, 6'd2, 0, 0);
        issue(0, I_SRET, 2'd1, 0, 6'd0, 1, 1);
        issue(0, I_SRET, 2'd2, 1, 6'd2, 0, 0);
        issue(0, I_SRET, 2'd3, 0, 6'd0, 1, 1);

        // processing on accept, and for non-matching instructions
        drive(0, I_ECALL, 2'd3);
        #2 chk("processing_match", 32'(if_a.processing), 1);
        push_exp(0, 1, 6'd11, 0, 0, ncyc + 2);
        tick(); rv = 3'b000; tick();
        drive(0, 12'h7ff, 2'd3);
        #2 chk("processing_bad_imm", 32'(if_a.processing), 0);
        opcode = 7'b0110011; imm = I_ECALL;
        #1 chk("processing_bad_opcode", 32'(if_a.processing), 0);
        tick(); rv = 3'b000; tick();

        // S_MODE_EN=0: SRET not recognised, S-mode ECALL reports cause 11
        drive(2, I_SRET, 2'd1);
        #2 chk("processing_sret_nos", 32'(if_c.processing), 0);
        tick(); rv = 3'b000; tick();
        issue(2, I_ECALL, 2'd1, 1, 6'd11, 0, 0);

        // WFI released by interrupt five cycles after accept
        drive(0, I_WFI, 2'd0);
        tick(); rv = 3'b000;
        for (int i = 0; i < 4; i++) begin
            chk("wfi_active_wait", 32'(if_a.wfi_active), 1);
            tick();
        end
        intp = 1'b1;
        push_exp(0, 0, 6'd0, 0, 0, ncyc + 2);
        tick(); intp = 1'b0;
        tick();
        chk("wfi_active_done", 32'(if_a.wfi_active), 0);

        // Interrupt already high on the accept cycle still passes WFI_WAIT
        drive(0, I_WFI, 2'd3);
        intp = 1'b1;
        push_exp(0, 0, 6'd0, 0, 0, ncyc + 3);
        tick(); rv = 3'b000;
        chk("wfi_active_early_int", 32'(if_a.wfi_active), 1);
        tick(); intp = 1'b0;
        tick();

        // WFI_TIMEOUT=4: completion at N+1+4
        drive(1, I_WFI, 2'd0);
        push_exp(1, 0, 6'd0, 0, 0, ncyc + 6);
        tick(); rv = 3'b000;
        repeat (6) tick();

        // Interrupt in the same cycle as the timeout: one completion only
        drive(1, I_WFI, 2'd3);
        push_exp(1, 0, 6'd0, 0, 0, ncyc + 6);
        tick(); rv = 3'b000;
        tick(); tick(); tick();
        intp = 1'b1;
        tick(); intp = 1'b0;
        repeat (3) tick();

        // WFI_TIMEOUT=0: waits indefinitely, then flushed
        drive(2, I_WFI, 2'd0);
        tick(); rv = 3'b000;
        repeat (1000) tick();
        chk("wfi_no_timeout_active", 32'(if_c.wfi_active), 1);
        flush = 1'b1;
        tick(); flush = 1'b0;
        chk("wfi_no_timeout_flushed", 32'(if_c.wfi_active), 0);

        // Flush during WFI_WAIT
        drive(0, I_WFI, 2'd3);
        tick(); rv = 3'b000;
        tick();
        flush = 1'b1;
        tick(); flush = 1'b0;
        chk("flush_wfi_active", 32'(if_a.wfi_active), 0);
        chk("flush_wfi_counter", 32'(dut_a.u_timer.count), 0);
        intp = 1'b1;
        tick(); tick(); intp = 1'b0;

        // Flush during RESP suppresses the strobe immediately
        drive(0, I_ECALL, 2'd3);
        tick(); rv = 3'b000;
        flush = 1'b1;
        #2 chk("flush_resp_valid", 32'(if_a.valid), 0);
        tick(); flush = 1'b0;
        tick();

        // Flush together with a match in IDLE: not accepted
        drive(0, I_EBREAK, 2'd3);
        flush = 1'b1;
        tick(); rv = 3'b000; flush = 1'b0;
        tick(); tick();

        // Asynchronous reset in the middle of WFI
        drive(0, I_WFI, 2'd3);
        tick(); rv = 3'b000;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wfi_active", 32'(if_a.wfi_active), 0);
        chk("rst_mid_processing", 32'(if_a.processing), 0);
        chk("rst_mid_counter", 32'(dut_a.u_timer.count), 0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(0, I_ECALL, 2'd3, 1, 6'd11, 0, 0);

        repeat (3) tick();
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/execute_system_priv.md
# execute_system_priv

Parametrised, sequential successor to the combinational privileged-instruction executor in the execute stage. It decodes SYSTEM/funct3=000 instructions (ECALL, EBREAK, MRET, SRET, WFI) and checks them against the current privilege mode. Results are registered with a one-cycle valid pulse. WFI stalls the stage until an interrupt is pending or a configurable timeout expires. Outputs feed the trap/CSR unit exactly as before, plus an SRET return flag and a WFI-active indication.

## Interface
- WFI_TIMEOUT, default 1024: cycles in WFI_WAIT before forced completion; 0 = no timeout.
- S_MODE_EN, default 1: 1 = SRET decoded and S-mode ECALL code used; 0 = SRET not recognised.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- decode_opcode  in  7  instruction opcode.
- decode_funct3  in  3  funct3.
- decode_funct7  in  7  funct7 (unused, kept for port compatibility).
- decode_imm  in  12  I-immediate (funct12).
- read_valid  in  1  instruction presented; upstream holds fields stable until valid.
- priv_mode  in  2  current privilege: 0=U, 1=S, 3=M, 2=reserved (treated as U).
- interrupt_pending  in  1  any enabled interrupt pending (level).
- flush  in  1  pipeline flush; aborts the in-flight op.
- processing  out  1  block owns the current instruction.
- valid  out  1  one-cycle result strobe.
- exception_num_out  out  6  exception cause; valid with valid.
- exception_valid_out  out  1  raise exception; qualified by valid.
- exception_return_valid_out  out  1  xRET completes; qualified by valid.
- exception_return_sret_out  out  1  1 = SRET, 0 = MRET; qualified by exception_return_valid_out.
- wfi_active  out  1  high while in WFI_WAIT.

## Operation
- Match: read_valid && opcode=1110011 && funct3=000 && imm in {000, 001, 302, 105, plus 102 if S_MODE_EN}.
- States:
  - IDLE: on match, capture the result; go to RESP, or to WFI_WAIT for WFI.
  - WFI_WAIT: go to RESP when interrupt_pending, or when the counter reaches WFI_TIMEOUT−1 (WFI_TIMEOUT≠0).
  - RESP: valid=1 for one cycle, then IDLE.
- processing = (state==IDLE && match) || state!=IDLE.
- ECALL: exception_valid=1; cause 8 (U or reserved), 9 (S, S_MODE_EN=1; else 11), 11 (M).
- EBREAK: exception_valid=1, cause 3.
- MRET in M: return_valid=1, sret=0. MRET not in M: exception_valid=1, cause 2 (illegal).
- SRET in S or M: return_valid=1, sret=1. SRET in U/reserved: exception cause 2.
- WFI: no exception, no return; all modes legal.
- Exception and return are never both asserted.
- exception_num_out=0 whenever exception_valid_out=0.
- Non-matching instructions: processing=0; this block does not raise an illegal exception for them.
- WFI counter: width $clog2(WFI_TIMEOUT)+1; clears on entry to WFI_WAIT; increments once per WFI_WAIT cycle; never wraps.

## Timing
- Reset: state=IDLE, counter=0; valid, exception_*, return_*, wfi_active all 0. processing stays 0 while read_valid=0.
- Non-WFI latency: accept in cycle N, valid in N+1. The next instruction can be accepted in N+2.
- WFI: earliest valid at N+2 (interrupt_pending high at N+1). Without an interrupt, valid at N+1+WFI_TIMEOUT.
- interrupt_pending high during the accept cycle does not skip WFI_WAIT.
- flush has top priority in any state: next state IDLE, counter cleared, no valid. Flush in the RESP cycle suppresses valid combinationally.
- Flush together with a new match in IDLE: not accepted.
- Interrupt and timeout in the same cycle: single completion, identical result.
- rst_n assertion mid-op: immediate IDLE; outputs 0 asynchronously.

## Structure
- Package priv_pkg:
  - SYSTEM_OPCODE, PRIV_FUNCT3.
  - ECALL/EBREAK/WFI/MRET/SRET imm constants.
  - Exception causes 2, 3, 8, 9, 11.
  - Privilege encodings.
  - State enum {IDLE, WFI_WAIT, RESP}.
- Sub-module wfi_timer (clear, enable, param WFI_TIMEOUT → expired). The rest is flat.

## Test plan
- ECALL with priv=3 → valid one cycle after accept, exception_valid=1, num=11. Repeat with priv 0/1/2 → 8/9/8.
- EBREAK then MRET (priv=3) back-to-back → two valid pulses two cycles apart: (exc, 3) then (return, sret=0).
- MRET with priv=1 → exception cause 2, no return. SRET with priv=0 → cause 2. SRET with priv=1 → return, sret=1. S_MODE_EN=0 + SRET → processing=0.
- WFI, interrupt_pending asserted 5 cycles later → wfi_active high meanwhile, valid exactly 1 cycle after the interrupt, no exception/return.
- WFI with WFI_TIMEOUT=4, no interrupt → valid 5 cycles after accept. With WFI_TIMEOUT=0 → no valid for 1000 cycles.
- Flush at WFI_WAIT and at RESP; rst_n low mid-WFI → no valid, state IDLE, counter 0, next ECALL completes normally.
